// File: rtl/spatz_perf_sampler_pkg.sv
// Shared types and constants for the perf counter sampler.
package spatz_perf_sampler_pkg;

  localparam int unsigned CounterWidth  = 48;
  localparam int unsigned CounterStride = 8;

  typedef enum logic [1:0] {
    Idle,
    Read,
    Clear,
    Done
  } state_e;

  // Default register bus request/response types (32-bit address, 64-bit data).
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        valid;
  } perf_reg_req_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        error;
    logic        ready;
  } perf_reg_rsp_t;

endpackage

// File: rtl/spatz_perf_sampler_timer.sv
// Periodic trigger source: down-counter that fires on reaching 1 and reloads from period_i.
module spatz_perf_sampler_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic [31:0] period_i,
  output logic        fire_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cur;

  // A stored zero means "freshly loaded": the live period_i is the current count.
  always_comb begin
    cur    = (cnt_q == '0) ? period_i : cnt_q;
    cnt_d  = period_i;
    fire_o = 1'b0;
    if (enable_i && (period_i != '0)) begin
      if (cur == 32'd1) begin
        fire_o = 1'b1;
      end else begin
        cnt_d = cur - 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spatz_perf_sampler.sv
// Reg bus initiator that reads (and optionally clears) the perf counters and publishes
// a coherent double-buffered snapshot.
module spatz_perf_sampler
  import spatz_perf_sampler_pkg::*;
#(
  parameter int unsigned          NumCounters  = 16,
  parameter int unsigned          AddrWidth    = 32,
  parameter int unsigned          DataWidth    = 64,
  parameter logic [AddrWidth-1:0] PerfBaseAddr = '0,
  parameter type                  reg_req_t    = perf_reg_req_t,
  parameter type                  reg_rsp_t    = perf_reg_rsp_t
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                enable_i,
  input  logic [31:0]                         period_i,
  input  logic                                trigger_i,
  input  logic                                clear_on_sample_i,
  input  logic                                clear_status_i,
  output reg_req_t                            reg_req_o,
  input  reg_rsp_t                            reg_rsp_i,
  output logic [NumCounters*CounterWidth-1:0] snapshot_o,
  output logic                                snapshot_valid_o,
  output logic                                busy_o,
  output logic [31:0]                         sample_count_o,
  output logic                                err_o,
  output logic                                overrun_o
);

  localparam int unsigned IdxWidth = (NumCounters > 1) ? $clog2(NumCounters) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumCounters - 1);

  state_e                                   state_q, state_d;
  logic [IdxWidth-1:0]                      idx_q, idx_d;
  logic                                     clr_mode_q, clr_mode_d;
  logic [NumCounters-1:0][CounterWidth-1:0] shadow_q, shadow_d;
  logic [NumCounters-1:0][CounterWidth-1:0] snap_q, snap_d;
  logic [31:0]                              count_q, count_d;
  logic                                     err_q, err_d;
  logic                                     ovr_q, ovr_d;

  logic                 fire;
  logic                 start;
  logic                 req_active;
  logic                 beat_done;
  logic                 last;
  logic [AddrWidth-1:0] addr;

  spatz_perf_sampler_timer u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (enable_i),
    .period_i (period_i),
    .fire_o   (fire)
  );

  assign start      = trigger_i | fire;
  assign req_active = (state_q == Read) || (state_q == Clear);
  assign beat_done  = req_active & reg_rsp_i.ready;
  assign last       = (idx_q == LastIdx);
  assign addr       = PerfBaseAddr + AddrWidth'(idx_q) * AddrWidth'(CounterStride);

  generate
    if (DataWidth > CounterWidth) begin : gen_unused_rdata
      logic unused_rdata;
      assign unused_rdata = ^reg_rsp_i.rdata[DataWidth-1:CounterWidth];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_mode_d = clr_mode_q;
    shadow_d   = shadow_q;
    snap_d     = snap_q;
    count_d    = count_q;
    // A new event in the same cycle as clear_status_i must win.
    err_d      = err_q & ~clear_status_i;
    ovr_d      = ovr_q & ~clear_status_i;

    if (start && (state_q != Idle)) begin
      ovr_d = 1'b1;
    end

    unique case (state_q)
      Idle: begin
        if (start) begin
          state_d    = Read;
          idx_d      = '0;
          clr_mode_d = clear_on_sample_i;
        end
      end
      Read: begin
        if (beat_done) begin
          shadow_d[idx_q] = reg_rsp_i.error ? '0 : reg_rsp_i.rdata[CounterWidth-1:0];
          if (reg_rsp_i.error) begin
            err_d = 1'b1;
          end
          if (clr_mode_q) begin
            state_d = Clear;
          end else if (last) begin
            state_d = Done;
          end else begin
            idx_d = idx_q + IdxWidth'(1);
          end
        end
      end
      Clear: begin
        if (beat_done) begin
          if (reg_rsp_i.error) begin
            err_d = 1'b1;
          end
          if (last) begin
            state_d = Done;
          end else begin
            state_d = Read;
            idx_d   = idx_q + IdxWidth'(1);
          end
        end
      end
      Done: begin
        snap_d  = shadow_q;
        count_d = count_q + 32'd1;
        state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  always_comb begin
    reg_req_o = '0;
    if (req_active) begin
      reg_req_o.valid = 1'b1;
      reg_req_o.addr  = addr;
      reg_req_o.write = (state_q == Clear);
      reg_req_o.wdata = '0;
      if (state_q == Clear) begin
        reg_req_o.wstrb = '1;
      end
    end
  end

  // During the commit cycle show the new data so it lines up with the valid pulse.
  assign snapshot_o       = (state_q == Done) ? shadow_q : snap_q;
  assign snapshot_valid_o = (state_q == Done);
  assign busy_o           = (state_q != Idle);
  assign sample_count_o   = count_q;
  assign err_o            = err_q;
  assign overrun_o        = ovr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      idx_q      <= '0;
      clr_mode_q <= 1'b0;
      shadow_q   <= '0;
      snap_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_mode_q <= clr_mode_d;
      shadow_q   <= shadow_d;
      snap_q     <= snap_d;
      count_q    <= count_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
    end
  end

endmodule

// File: tb/tb_spatz_perf_sampler.sv
// Directed bench for spatz_perf_sampler with a 4-counter reg bus responder model.
module tb_spatz_perf_sampler;
  import spatz_perf_sampler_pkg::*;

  localparam int unsigned N = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable, trigger, clr_on, clear_status;
  logic [31:0]       period;
  perf_reg_req_t     req;
  perf_reg_rsp_t     rsp;
  logic [N*48-1:0]   snapshot;
  logic              snap_valid, busy, err, ovr;
  logic [31:0]       count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int delay = 1;
  int wait_q = 0;
  bit err_en = 1'b0;
  logic [31:0] err_addr = 32'd16;

  logic [31:0] beat_addr[$];
  bit          beat_wr[$];
  logic [63:0] beat_wdata[$];
  logic [7:0]  beat_wstrb[$];
  int          beat_cyc[$];
  int          vq[$];

  spatz_perf_sampler #(
    .NumCounters  (N),
    .AddrWidth    (32),
    .DataWidth    (64),
    .PerfBaseAddr (32'h0)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .enable_i          (enable),
    .period_i          (period),
    .trigger_i         (trigger),
    .clear_on_sample_i (clr_on),
    .clear_status_i    (clear_status),
    .reg_req_o         (req),
    .reg_rsp_i         (rsp),
    .snapshot_o        (snapshot),
    .snapshot_valid_o  (snap_valid),
    .busy_o            (busy),
    .sample_count_o    (count),
    .err_o             (err),
    .overrun_o         (ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: ready after `delay` cycles of valid, rdata = counter index + 100.
  always_comb begin
    rsp       = '0;
    rsp.ready = (wait_q == delay - 1);
    rsp.rdata = 64'(req.addr >> 3) + 64'd100;
    rsp.error = err_en && !req.write && (req.addr == err_addr);
  end

  always @(posedge clk) begin
    if (req.valid && !rsp.ready) wait_q <= wait_q + 1;
    else wait_q <= 0;
  end

  always @(negedge clk) begin
    if (rst_n && req.valid && rsp.ready) begin
      beat_addr.push_back(req.addr);
      beat_wr.push_back(req.write);
      beat_wdata.push_back(req.wdata);
      beat_wstrb.push_back(req.wstrb);
      beat_cyc.push_back(cyc);
    end
    if (snap_valid) vq.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    beat_addr.delete();
    beat_wr.delete();
    beat_wdata.delete();
    beat_wstrb.delete();
    beat_cyc.delete();
    vq.delete();
  endtask

  task automatic pulse_trigger(output int t0);
    t0 = cyc;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      if (vq.size() > 0) begin
        at = vq[0];
        return;
      end
      step();
    end
    check_eq("valid_timeout", 64'(vq.size()), 64'd1);
  endtask

  task automatic check_snap(input string tag, input int zero_idx);
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("%s[%0d]", tag, i), 64'(snapshot[i*48 +: 48]),
               (i == zero_idx) ? 64'd0 : 64'(100 + i));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, at, e;
    rst_n = 1'b1;
    enable = 1'b0; trigger = 1'b0; clr_on = 1'b0; clear_status = 1'b0; period = 32'd0;
    #2 rst_n = 1'b0;
    step(); step();
    check_eq("rst_valid", 64'(req.valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_snap_valid", 64'(snap_valid), 64'd0);
    check_eq("rst_snapshot", 64'(|snapshot), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_err_ovr", 64'({err, ovr}), 64'd0);
    rst_n = 1'b1;
    step();

    // Read-only sample, always-ready responder.
    clear_logs();
    pulse_trigger(t0);
    wait_valid(30, at);
    check_eq("rd_valid_cycle", 64'(at - t0), 64'd5);
    check_eq("rd_busy_done", 64'(busy), 64'd1);
    check_eq("rd_beats", 64'(beat_addr.size()), 64'd4);
    for (int i = 0; i < 4 && i < beat_addr.size(); i++) begin
      check_eq($sformatf("rd_addr%0d", i), 64'(beat_addr[i]), 64'(8 * i));
      check_eq($sformatf("rd_wr%0d", i), 64'(beat_wr[i]), 64'd0);
      check_eq($sformatf("rd_cyc%0d", i), 64'(beat_cyc[i] - t0), 64'(1 + i));
    end
    check_snap("rd_snap", -1);
    step();
    check_eq("rd_count", 64'(count), 64'd1);
    check_eq("rd_busy_after", 64'(busy), 64'd0);
    check_eq("rd_valid_pulse", 64'(snap_valid), 64'd0);
    check_snap("rd_snap_held", -1);

    // Clear-on-sample: alternating read / write-0 per address.
    clear_logs();
    clr_on = 1'b1;
    pulse_trigger(t0);
    clr_on = 1'b0;
    wait_valid(30, at);
    check_eq("clr_valid_cycle", 64'(at - t0), 64'd9);
    check_eq("clr_beats", 64'(beat_addr.size()), 64'd8);
    for (int j = 0; j < 8 && j < beat_addr.size(); j++) begin
      check_eq($sformatf("clr_addr%0d", j), 64'(beat_addr[j]), 64'(8 * (j / 2)));
      check_eq($sformatf("clr_wr%0d", j), 64'(beat_wr[j]), 64'(j % 2));
      check_eq($sformatf("clr_wdata%0d", j), beat_wdata[j], 64'd0);
      if (j % 2 == 1) check_eq($sformatf("clr_wstrb%0d", j), 64'(beat_wstrb[j]), 64'hFF);
    end
    check_snap("clr_snap", -1);
    step();
    check_eq("clr_count", 64'(count), 64'd2);

    // Slow responder: request held stable until ready on the third cycle.
    delay = 3;
    clear_logs();
    pulse_trigger(t0);
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 3; w++) begin
        check_eq($sformatf("slow_valid%0d_%0d", k, w), 64'(req.valid), 64'd1);
        check_eq($sformatf("slow_addr%0d_%0d", k, w), 64'(req.addr), 64'(8 * k));
        check_eq($sformatf("slow_wr%0d_%0d", k, w), 64'(req.write), 64'd0);
        check_eq($sformatf("slow_rdy%0d_%0d", k, w), 64'(rsp.ready), 64'(w == 2));
        step();
      end
    end
    check_eq("slow_snap_valid", 64'(snap_valid), 64'd1);
    check_snap("slow_snap", -1);
    delay = 1;
    step();
    check_eq("slow_count", 64'(count), 64'd3);

    // Error on counter 2 read.
    err_en = 1'b1;
    clear_logs();
    pulse_trigger(t0);
    wait_valid(30, at);
    check_snap("err_snap", 2);
    step();
    check_eq("err_set", 64'(err), 64'd1);
    check_eq("err_count", 64'(count), 64'd4);
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    check_eq("err_cleared", 64'(err), 64'd0);
    clear_logs();
    pulse_trigger(t0);
    step();
    step();
    clear_status = 1'b1;   // same cycle as the counter 2 error beat
    step();
    clear_status = 1'b0;
    check_eq("err_set_wins", 64'(err), 64'd1);
    wait_valid(30, at);
    step();
    check_eq("err2_count", 64'(count), 64'd5);
    err_en = 1'b0;

    // Periodic timer with a dropped manual trigger while busy.
    period = 32'd10;
    step();
    check_eq("ovr_before", 64'(ovr), 64'd0);
    clear_logs();
    enable = 1'b1;
    e = cyc;
    while (cyc < e + 11) step();
    check_eq("per_busy", 64'(busy), 64'd1);
    pulse_trigger(t0);
    while (cyc < e + 36) step();
    enable = 1'b0;
    step(); step();
    check_eq("per_nvalid", 64'(vq.size()), 64'd3);
    for (int i = 0; i < 3 && i < vq.size(); i++) begin
      check_eq($sformatf("per_valid%0d", i), 64'(vq[i] - e), 64'(14 + 10 * i));
    end
    check_eq("per_overrun", 64'(ovr), 64'd1);
    check_eq("per_count", 64'(count), 64'd8);

    // Asynchronous reset mid-sequence, then restart from counter 0.
    clear_logs();
    pulse_trigger(t0);
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 64'(req.valid), 64'd0);
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_snapshot", 64'(|snapshot), 64'd0);
    check_eq("arst_count", 64'(count), 64'd0);
    check_eq("arst_err_ovr", 64'({err, ovr}), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    clear_logs();
    pulse_trigger(t0);
    wait_valid(30, at);
    check_eq("rr_valid_cycle", 64'(at - t0), 64'd5);
    check_eq("rr_first_addr", (beat_addr.size() > 0) ? 64'(beat_addr[0]) : 64'hDEAD, 64'd0);
    check_eq("rr_first_cyc", (beat_cyc.size() > 0) ? 64'(beat_cyc[0] - t0) : 64'hDEAD, 64'd1);
    check_snap("rr_snap", -1);
    step();
    check_eq("rr_count", 64'(count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
